// File: rtl/lsu.sv
// lsu: load/store unit between the MEM stage and word-wide data memory.
// Sub-word loads are extracted/extended; sub-word stores do read-modify-write.
module lsu #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wmem,
  output logic        mem_rmem,
  output logic [1:0]  mem_memsz,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic        accept;
  logic        req_fault;
  logic        oob;
  logic [31:0] ld_val;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_ready = (state_q == S_IDLE) & rst;
  assign accept    = req_valid & req_ready;

  assign oob = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

  // Reject reserved size, misaligned half/word and out-of-range addresses
  always_comb begin
    req_fault = oob;
    unique case (req_size)
      SZ_B:    req_fault = oob;
      SZ_H:    req_fault = oob | req_addr[0];
      SZ_W:    req_fault = oob | (req_addr[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  end

  assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  // Extract the addressed lane and sign/zero extend it
  always_comb begin
    ld_val = mem_rdata;
    unique case (size_q)
      SZ_B:    ld_val = {{24{~uns_q & lane_b[7]}}, lane_b};
      SZ_H:    ld_val = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_val = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the current memory word with store data
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_B)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          fault_d = req_fault;
          if (req_fault) begin
            rdata_d = 32'h0;
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = ld_val;
          state_d = S_RESP;
        end else begin
          rdata_d = 32'h0;
          if (size_q == SZ_W) begin
            state_d = S_RESP;
          end else begin
            merge_d = merged;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Memory port decodes only from state and captured registers
  always_comb begin
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    mem_rmem  = 1'b0;
    mem_wmem  = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        mem_rmem = rst;
        mem_wmem = rst & we_q & (size_q == SZ_W);
      end
      S_WRITE: begin
        mem_wdata = merge_q;
        mem_wmem  = rst;
      end
      default: ;
    endcase
    mem_memsz = (mem_rmem | mem_wmem) ? 2'b10 : 2'b00;
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
// Models a combinational-read, synchronous-write word memory.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wmem;
  logic        mem_rmem;
  logic [1:0]  mem_memsz;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  int nvec;
  int nfail;

  int          r_cyc;
  logic [31:0] r_rdata;
  logic        r_fault;
  int          w_cnt;
  int          w_cyc;
  logic [31:0] w_addr;
  int          rm_cnt;

  lsu #(.MEM_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmem     (mem_wmem),
    .mem_rmem     (mem_rmem),
    .mem_memsz    (mem_memsz),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_idx] <= pl_data;
    else if (mem_wmem)
      mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_idx  = a[11:2];
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request from IDLE and observe it until its response.
  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic u);
    r_cyc   = -1;
    r_rdata = 32'hx;
    r_fault = 1'bx;
    w_cnt   = 0;
    w_cyc   = -1;
    w_addr  = 32'hx;
    rm_cnt  = 0;
    @(negedge clk);
    req_we       = we;
    req_addr     = a;
    req_wdata    = wd;
    req_size     = sz;
    req_unsigned = u;
    req_valid    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_wmem) begin
        w_cnt++;
        w_cyc  = c;
        w_addr = mem_addr;
      end
      if (mem_rmem) rm_cnt++;
      if (resp_valid) begin
        r_cyc   = c;
        r_rdata = resp_rdata;
        r_fault = resp_fault;
        break;
      end
    end
  endtask

  logic [31:0] q_addr [0:2];
  logic [1:0]  q_size [0:2];
  logic        q_uns  [0:2];
  logic [31:0] q_exp  [0:2];
  logic [31:0] got    [0:2];
  int          nresp;
  int          nacc;
  int          idx;
  logic        acc_pend;

  initial begin
    nvec = 0;
    nfail = 0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    pl_we = 1'b0;
    pl_idx = 10'h0;
    pl_data = 32'h0;

    preload(32'h100, 32'h80817F01);
    preload(32'h104, 32'h00000000);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_fault", {31'h0, resp_fault}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_wmem", {31'h0, mem_wmem}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Loads against word 0x100 = 0x80817F01
    do_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
    chk("lb_data", r_rdata, 32'hFFFFFF80);
    chk("lb_cyc", r_cyc, 2);
    chk("lb_wmem", w_cnt, 0);
    do_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b1);
    chk("lbu_data", r_rdata, 32'h00000080);
    do_req(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
    chk("lh_data", r_rdata, 32'hFFFF8081);
    chk("lh_cyc", r_cyc, 2);
    do_req(1'b0, 32'h100, 32'h0, 2'b01, 1'b1);
    chk("lhu_data", r_rdata, 32'h00007F01);
    do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    chk("lw_data", r_rdata, 32'h80817F01);
    chk("lw_cyc", r_cyc, 2);
    chk("lw_wmem", w_cnt, 0);
    chk("lw_fault", {31'h0, r_fault}, 32'h0);

    // Sub-word stores via read-modify-write
    do_req(1'b1, 32'h101, 32'h12345655, 2'b00, 1'b0);
    chk("sb_cyc", r_cyc, 3);
    chk("sb_wcnt", w_cnt, 1);
    chk("sb_wcyc", w_cyc, 2);
    chk("sb_rdata", r_rdata, 32'h0);
    chk("sb_mem", mem[32'h100 >> 2], 32'h80815501);
    do_req(1'b1, 32'h102, 32'h0000BEEF, 2'b01, 1'b0);
    chk("sh_cyc", r_cyc, 3);
    chk("sh_wcnt", w_cnt, 1);
    chk("sh_wcyc", w_cyc, 2);
    chk("sh_mem", mem[32'h100 >> 2], 32'hBEEF5501);

    // Word store and readback
    do_req(1'b1, 32'h104, 32'hDEADBEEF, 2'b10, 1'b0);
    chk("sw_wcyc", w_cyc, 1);
    chk("sw_wcnt", w_cnt, 1);
    chk("sw_waddr", w_addr, 32'h104);
    chk("sw_cyc", r_cyc, 2);
    chk("sw_fault", {31'h0, r_fault}, 32'h0);
    do_req(1'b0, 32'h104, 32'h0, 2'b10, 1'b0);
    chk("sw_readback", r_rdata, 32'hDEADBEEF);

    // Faulting requests
    do_req(1'b0, 32'h102, 32'h0, 2'b10, 1'b0);
    chk("f_lw_cyc", r_cyc, 1);
    chk("f_lw_fault", {31'h0, r_fault}, 32'h1);
    chk("f_lw_rdata", r_rdata, 32'h0);
    chk("f_lw_mem", w_cnt + rm_cnt, 0);
    do_req(1'b0, 32'h101, 32'h0, 2'b01, 1'b0);
    chk("f_lh_cyc", r_cyc, 1);
    chk("f_lh_fault", {31'h0, r_fault}, 32'h1);
    chk("f_lh_mem", w_cnt + rm_cnt, 0);
    do_req(1'b1, 32'h100, 32'h0, 2'b11, 1'b0);
    chk("f_sz3_cyc", r_cyc, 1);
    chk("f_sz3_fault", {31'h0, r_fault}, 32'h1);
    chk("f_sz3_mem", w_cnt + rm_cnt, 0);
    do_req(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0);
    chk("f_oob_cyc", r_cyc, 1);
    chk("f_oob_fault", {31'h0, r_fault}, 32'h1);
    chk("f_oob_mem", w_cnt + rm_cnt, 0);
    chk("f_mem_intact", mem[32'h100 >> 2], 32'hBEEF5501);

    // Three requests with req_valid held high
    q_addr[0] = 32'h100; q_size[0] = 2'b10; q_uns[0] = 1'b0;
    q_exp[0]  = 32'hBEEF5501;
    q_addr[1] = 32'h104; q_size[1] = 2'b10; q_uns[1] = 1'b0;
    q_exp[1]  = 32'hDEADBEEF;
    q_addr[2] = 32'h100; q_size[2] = 2'b00; q_uns[2] = 1'b1;
    q_exp[2]  = 32'h00000001;
    nresp = 0;
    nacc = 0;
    idx = 0;
    acc_pend = 1'b0;
    for (int k = 0; k < 3; k++) got[k] = 32'hx;
    @(negedge clk);
    req_we       = 1'b0;
    req_addr     = q_addr[0];
    req_size     = q_size[0];
    req_unsigned = q_uns[0];
    req_valid    = 1'b1;
    if (req_ready) acc_pend = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid && nresp < 3) begin
        got[nresp] = resp_rdata;
        nresp++;
      end
      if (acc_pend) begin
        nacc++;
        idx++;
        acc_pend = 1'b0;
        if (idx < 3) begin
          req_addr     = q_addr[idx];
          req_size     = q_size[idx];
          req_unsigned = q_uns[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_valid && req_ready) acc_pend = 1'b1;
      if (nresp == 3 && !req_valid) break;
    end
    req_valid = 1'b0;
    chk("q_nresp", nresp, 3);
    chk("q_nacc", nacc, 3);
    chk("q_resp0", got[0], q_exp[0]);
    chk("q_resp1", got[1], q_exp[1]);
    chk("q_resp2", got[2], q_exp[2]);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    req_we       = 1'b1;
    req_addr     = 32'h100;
    req_wdata    = 32'h000000AA;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ra_access_rmem", {31'h0, mem_rmem}, 32'h1);
    @(negedge clk);
    chk("ra_write_wmem", {31'h0, mem_wmem}, 32'h1);
    rst = 1'b0;
    #1;
    chk("ra_wmem_gated", {31'h0, mem_wmem}, 32'h0);
    chk("ra_memsz_gated", {30'h0, mem_memsz}, 32'h0);
    @(negedge clk);
    chk("ra_no_resp", {31'h0, resp_valid}, 32'h0);
    chk("ra_rdata_clr", resp_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ra_no_resp2", {31'h0, resp_valid}, 32'h0);
    chk("ra_ready", {31'h0, req_ready}, 32'h1);
    chk("ra_mem_intact", mem[32'h100 >> 2], 32'hBEEF5501);
    do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    chk("ra_lw", r_rdata, 32'hBEEF5501);
    chk("ra_lw_cyc", r_cyc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
